// File: rtl/apb_global_pkg.sv
// Bus widths and FSM state type shared by the APB slave memory and its users.
package apb_global_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int DATA_WIDTH    = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// Word storage for the APB slave: byte-strobed synchronous write, combinational read.
module apb_slave_regfile #(
   parameter int DATA_WIDTH = apb_global_pkg::DATA_WIDTH,
   parameter int DEPTH      = 16,
   parameter int IDX_W      = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    we_i,
   input  logic [IDX_W-1:0]        waddr_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [IDX_W-1:0]        raddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the storage array is cleared by reset on purpose, because software
   // relies on reading zero from every word after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave memory: setup/access/done FSM with programmable wait states,
// error decode and registered pready/prdata/pslverr.
module apb_slave_mem #(
   parameter int ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
   parameter int DEPTH         = 16,
   parameter int PROT_BASE     = 12
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic                     psel,
   input  logic                     penable,
   input  logic [ADDRESS_WIDTH-1:0] paddr,
   input  logic                     pwrite,
   input  logic [DATA_WIDTH/8-1:0]  pstrb,
   input  logic [DATA_WIDTH-1:0]    pwdata,
   input  logic [2:0]               pprot,
   input  logic [3:0]               wait_cfg,
   output logic                     pready,
   output logic [DATA_WIDTH-1:0]    prdata,
   output logic                     pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WORD_W = ADDRESS_WIDTH - 2;

   apb_global_pkg::apb_slave_state_e state_q, state_d;

   logic [3:0]               wait_cnt_q, wait_cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     write_q, write_d;
   logic [STRB_W-1:0]        strb_q, strb_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     priv_q, priv_d;
   logic                     pready_q, pready_d;
   logic [DATA_WIDTH-1:0]    prdata_q, prdata_d;
   logic                     pslverr_q, pslverr_d;

   logic [WORD_W-1:0]        word_idx;
   logic                     err;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_rdata;
   logic                     unused_prot;

   assign unused_prot = ^pprot[2:1];

   // Error decode works on the latched request so it is stable for the whole transfer.
   assign word_idx = addr_q[ADDRESS_WIDTH-1:2];
   assign err = (addr_q[1:0] != 2'b00)
             || (word_idx >= WORD_W'(DEPTH))
             || (write_q && !priv_q && (word_idx >= WORD_W'(PROT_BASE)));

   assign mem_we = (state_q == apb_global_pkg::DONE) && psel && penable && write_q && !err;

   apb_slave_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_regfile (
      .clk_i   (pclk),
      .rst_i   (preset),
      .we_i    (mem_we),
      .waddr_i (addr_q[IDX_W+1:2]),
      .wstrb_i (strb_q),
      .wdata_i (wdata_q),
      .raddr_i (addr_q[IDX_W+1:2]),
      .rdata_o (mem_rdata)
   );

   // NOTE: every _d signal takes its default first, so no branch can leave one
   // unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      write_d    = write_q;
      strb_d     = strb_q;
      wdata_d    = wdata_q;
      priv_d     = priv_q;
      pready_d   = 1'b0;
      prdata_d   = '0;
      pslverr_d  = 1'b0;

      case (state_q)
         apb_global_pkg::IDLE: begin
            if (psel && !penable) begin
               addr_d     = paddr;
               write_d    = pwrite;
               strb_d     = pstrb;
               wdata_d    = pwdata;
               priv_d     = pprot[0];
               wait_cnt_d = wait_cfg;
               state_d    = apb_global_pkg::ACCESS;
            end
         end
         apb_global_pkg::ACCESS: begin
            if (!psel) begin
               wait_cnt_d = '0;
               state_d    = apb_global_pkg::IDLE;
            end else if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else begin
               pready_d  = 1'b1;
               pslverr_d = err;
               prdata_d  = (err || write_q) ? '0 : mem_rdata;
               state_d   = apb_global_pkg::DONE;
            end
         end
         apb_global_pkg::DONE: begin
            state_d = apb_global_pkg::IDLE;
         end
         default: begin
            state_d = apb_global_pkg::IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= apb_global_pkg::IDLE;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         strb_q     <= '0;
         wdata_q    <= '0;
         priv_q     <= 1'b0;
         pready_q   <= 1'b0;
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         strb_q     <= strb_d;
         wdata_q    <= wdata_d;
         priv_q     <= priv_d;
         pready_q   <= pready_d;
         prdata_q   <= prdata_d;
         pslverr_q  <= pslverr_d;
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed vector table, abort/reset
// sequences and randomized transfers against a word-array reference model.
module tb_apb_slave_mem;

   localparam int DEPTH     = 16;
   localparam int PROT_BASE = 12;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic [2:0]  pprot;
   logic [3:0]  wait_cfg;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [DEPTH];

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] data;
      logic [2:0]  prot;
      logic [3:0]  wc;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   apb_slave_mem #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .DEPTH         (DEPTH),
      .PROT_BASE     (PROT_BASE)
   ) dut (
      .pclk     (pclk),
      .preset   (preset),
      .psel     (psel),
      .penable  (penable),
      .paddr    (paddr),
      .pwrite   (pwrite),
      .pstrb    (pstrb),
      .pwdata   (pwdata),
      .pprot    (pprot),
      .wait_cfg (wait_cfg),
      .pready   (pready),
      .prdata   (prdata),
      .pslverr  (pslverr)
   );

   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic wr, input logic [2:0] prot);
      return ((a % 4) != 0) || ((a / 4) >= DEPTH) || (wr && ((a / 4) >= PROT_BASE) && !prot[0]);
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [3:0] strb,
                                       input logic [31:0] d);
      logic [31:0] mask = '0;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) mask = mask | (32'hFF << (8 * b));
      end
      model[a / 4] = (model[a / 4] & ~mask) | (d & mask);
   endfunction

   // One full APB transfer; address/data/control are scrambled during the
   // access phase to show the slave works from its setup-cycle copy.
   task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [3:0] strb,
                           input logic [31:0] d, input logic [2:0] prot, input logic [3:0] wc,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output logic clean);
      clean = 1'b1;
      lat   = -1;
      rdata = '0;
      err   = 1'b0;
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pstrb = strb;
      pwdata = d; pprot = prot; wait_cfg = wc;
      @(posedge pclk); #1;
      if (pready) clean = 1'b0;
      @(negedge pclk);
      penable  = 1'b1;
      paddr    = $urandom;
      pwrite   = 1'($urandom);
      pstrb    = 4'($urandom);
      pwdata   = $urandom;
      pprot    = 3'($urandom);
      wait_cfg = 4'($urandom);
      for (int c = 1; c <= 40; c++) begin
         @(posedge pclk); #1;
         if (pready) begin
            lat   = c;
            rdata = prdata;
            err   = pslverr;
            break;
         end
         if (prdata !== 32'h0 || pslverr !== 1'b0) clean = 1'b0;
      end
      if (lat >= 0) begin
         @(posedge pclk); #1;
         if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) clean = 1'b0;
      end
      psel = 1'b0;
      penable = 1'b0;
   endtask

   task automatic xfer_check(input string name, input logic [31:0] a, input logic wr,
                             input logic [3:0] strb, input logic [31:0] d, input logic [2:0] prot,
                             input logic [3:0] wc, input logic exp_err, input logic [31:0] exp_rdata);
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        cl;
      apb_xfer(a, wr, strb, d, prot, wc, rd, er, lat, cl);
      check({name, " latency"}, lat, 32'(wc) + 32'd1);
      check({name, " pslverr"}, er, exp_err);
      if (!wr || exp_err) check({name, " prdata"}, rd, exp_rdata);
      check({name, " idle outputs"}, cl, 1'b1);
      if (wr && !model_err(a, wr, prot)) model_write(a, strb, d);
   endtask

   initial begin
      logic        seen;
      logic [31:0] a;
      logic        wr;
      logic [2:0]  prot;
      logic        e;

      preset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
      pstrb = '0; pwdata = '0; pprot = '0; wait_cfg = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      preset = 1'b0;
      #1;
      check("reset pready", pready, 1'b0);
      check("reset prdata", prdata, 32'h0);
      check("reset pslverr", pslverr, 1'b0);

      //                addr      wr    strb   data          prot   wc    err   rdata
      vecs.push_back('{32'h04, 1'b1, 4'hF, 32'hDEADBEEF, 3'b000, 4'd0, 1'b0, 32'h0});
      vecs.push_back('{32'h04, 1'b0, 4'h0, 32'h0,        3'b000, 4'd0, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{32'h04, 1'b0, 4'h0, 32'h0,        3'b000, 4'd3, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{32'h08, 1'b1, 4'hF, 32'h11223344, 3'b000, 4'd0, 1'b0, 32'h0});
      vecs.push_back('{32'h08, 1'b1, 4'h5, 32'hAABBCCDD, 3'b000, 4'd1, 1'b0, 32'h0});
      vecs.push_back('{32'h08, 1'b0, 4'h0, 32'h0,        3'b000, 4'd0, 1'b0, 32'h11BB33DD});
      vecs.push_back('{32'h40, 1'b0, 4'h0, 32'h0,        3'b000, 4'd0, 1'b1, 32'h0});
      vecs.push_back('{32'h30, 1'b1, 4'hF, 32'h12345678, 3'b000, 4'd0, 1'b1, 32'h0});
      vecs.push_back('{32'h30, 1'b0, 4'h0, 32'h0,        3'b000, 4'd0, 1'b0, 32'h0});
      vecs.push_back('{32'h30, 1'b1, 4'hF, 32'hCAFEF00D, 3'b001, 4'd0, 1'b0, 32'h0});
      vecs.push_back('{32'h30, 1'b0, 4'h0, 32'h0,        3'b000, 4'd2, 1'b0, 32'hCAFEF00D});
      vecs.push_back('{32'h02, 1'b0, 4'h0, 32'h0,        3'b000, 4'd0, 1'b1, 32'h0});
      vecs.push_back('{32'h0C, 1'b1, 4'h0, 32'h00000055, 3'b000, 4'd0, 1'b0, 32'h0});
      vecs.push_back('{32'h0C, 1'b0, 4'h0, 32'h0,        3'b000, 4'd0, 1'b0, 32'h0});
      vecs.push_back('{32'h3C, 1'b0, 4'h0, 32'h0,        3'b000, 4'd1, 1'b0, 32'h0});
      vecs.push_back('{32'h2C, 1'b1, 4'hF, 32'h01020304, 3'b000, 4'd2, 1'b0, 32'h0});
      vecs.push_back('{32'h2C, 1'b0, 4'h0, 32'h0,        3'b000, 4'd1, 1'b0, 32'h01020304});
      vecs.push_back('{32'h3C, 1'b1, 4'hF, 32'hFFFFFFFF, 3'b110, 4'd0, 1'b1, 32'h0});
      vecs.push_back('{32'h40, 1'b1, 4'hF, 32'hFFFFFFFF, 3'b001, 4'd0, 1'b1, 32'h0});

      foreach (vecs[i]) begin
         xfer_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].strb,
                    vecs[i].data, vecs[i].prot, vecs[i].wc, vecs[i].exp_err, vecs[i].exp_rdata);
      end

      // Abort: psel drops in the third wait cycle of a 5-wait write.
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pstrb = 4'hF;
      pwdata = 32'h77777777; pprot = 3'b001; wait_cfg = 4'd5;
      @(posedge pclk);
      @(negedge pclk);
      penable = 1'b1;
      repeat (2) begin
         @(posedge pclk);
         @(negedge pclk);
      end
      psel = 1'b0;
      penable = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(posedge pclk); #1;
         if (pready) seen = 1'b1;
      end
      check("abort no pready", seen, 1'b0);
      xfer_check("abort no write", 32'h10, 1'b0, 4'h0, 32'h0, 3'b000, 4'd0, 1'b0, model[4]);

      // Reset in the middle of a write, then penable held high while idle.
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pstrb = 4'hF;
      pwdata = 32'h99999999; pprot = 3'b001; wait_cfg = 4'd2;
      @(posedge pclk);
      @(negedge pclk);
      penable = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      preset = 1'b1;
      @(posedge pclk); #1;
      check("midreset pready", pready, 1'b0);
      check("midreset prdata", prdata, 32'h0);
      check("midreset pslverr", pslverr, 1'b0);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(negedge pclk);
      preset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge pclk); #1;
         if (pready) seen = 1'b1;
      end
      check("penable in idle ignored", seen, 1'b0);
      psel = 1'b0;
      penable = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         xfer_check($sformatf("post-reset word%0d", i), 32'(i * 4), 1'b0, 4'h0, 32'h0,
                    3'b000, 4'd0, 1'b0, 32'h0);
      end

      // Randomized transfers against the reference model.
      for (int n = 0; n < 250; n++) begin
         a = 32'($urandom_range(0, 79));
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         if ($urandom_range(0, 15) == 0) a = $urandom;
         wr   = 1'($urandom);
         prot = 3'($urandom);
         e    = model_err(a, wr, prot);
         xfer_check($sformatf("rand%0d", n), a, wr, 4'($urandom), $urandom, prot,
                    4'($urandom_range(0, 3)), e, (wr || e) ? 32'h0 : model[a / 4]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
